pipe_stage_regs: RTL and testbench
==================================

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock for all state; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have these stage-control inputs from the hazard unit: StallF  in  1  hold PC; StallD  in  1  hold IF/ID; FlushE  in  1  bubble ID/EX; FlushD  in  1  branch-taken clear of IF/ID; cnt_clr  in  1  sync clear of counters.
REQ-003 SHALL have these fetch ports: PCNextF  in  32  next PC; PCF  out  32  current PC; InstrF  in  32  fetched instruction; PCPlus4F  in  32  PC+4.
REQ-004 SHALL have these decode outputs: InstrD  out  32; PCPlus4D  out  32.
REQ-005 SHALL have these decode-to-execute ports: CtrlD  in  8  {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}, MSB first; DataD  in  96  {RD1, RD2, SignImm}; RegsD  in  15  {Rs, Rt, Rd}; CtrlE  out  8; DataE  out  96; RegsE  out  15.
REQ-006 SHALL have these execute-to-memory ports: CtrlE2M  in  3  {RegWrite, MemtoReg, MemWrite} from EX; ALUOutE  in  32; WriteDataE  in  32; WriteRegE  in  5; CtrlM  out  3; ALUOutM  out  32; WriteDataM  out  32; WriteRegM  out  5.
REQ-007 SHALL have these memory-to-writeback ports: ReadDataM  in  32; CtrlW  out  2  {RegWrite, MemtoReg}; ReadDataW  out  32; ALUOutW  out  32; WriteRegW  out  5.
REQ-008 SHALL have these counter outputs: stall_cnt  out  16  cycles with StallF=1; flush_cnt  out  16  flush events.

Function
REQ-009 SHALL load PCF from PCNextF on each rising edge when StallF=0 and SHALL hold PCF when StallF=1.
REQ-010 SHALL resolve the IF/ID register with priority StallD > FlushD > load: StallD=1 holds; else FlushD=1 writes InstrD=0 and PCPlus4D=0; else InstrD and PCPlus4D are loaded from InstrF and PCPlus4F.
REQ-011 SHALL clear CtrlE, DataE and RegsE to all-zero when FlushE=1 at the edge, otherwise load them from CtrlD, DataD and RegsD; ID/EX has no stall hold.
REQ-012 SHALL load EX/MEM and MEM/WB every cycle (no stall, no flush), with CtrlW taken from CtrlM[2:1].
REQ-013 SHALL give each stage one cycle of latency: a value present at the D inputs at edge n appears at the E outputs after edge n, at the M outputs after edge n+1 and at the W outputs after edge n+2, absent stall or flush.
REQ-014 SHALL increment stall_cnt by 1 on each edge where StallF=1.
REQ-015 SHALL increment flush_cnt by 1 on each edge where FlushE=1 or (FlushD=1 and StallD=0); two simultaneous flush causes count as one increment.
REQ-016 SHALL saturate both counters at 16'hFFFF with no wrap.
REQ-017 SHALL clear both counters on cnt_clr=1, which overrides any increment in the same cycle.
REQ-018 SHALL have all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-019 SHALL, on rst_n=0, immediately (no clock needed) force PCF=32'h0000_0000, clear every pipeline register (so all control bits are 0 and no write occurs) and set both counters to 0.
REQ-020 SHALL resume normal operation on the first rising edge after rst_n deasserts; a reset asserted mid-stall discards held state.

Verification
REQ-021 Bench SHALL cover: rst_n=0 mid-run with no clock edge -> PCF=0, CtrlE=0, CtrlW=0, stall_cnt=0 immediately.
REQ-022 Bench SHALL cover: InstrF=32'h8C09_0004 with stalls and flushes low -> InstrD=32'h8C09_0004 after 1 edge; CtrlD=8'hC4 -> CtrlE=8'hC4 after 1 edge, CtrlM=3'b110 and CtrlW=2'b11 on the following edges.
REQ-023 Bench SHALL cover: StallF=StallD=FlushE=1 for 2 cycles -> PCF and InstrD unchanged, CtrlE=0, stall_cnt=2, flush_cnt=2.
REQ-024 Bench SHALL cover: FlushD=1 and StallD=1 together -> InstrD held and flush_cnt unchanged; FlushD=1 with StallD=0 -> InstrD=0 and flush_cnt+1.
REQ-025 Bench SHALL cover: stall_cnt preloaded to 16'hFFFE by holding StallF=1, then 3 more stall cycles -> stall_cnt=16'hFFFF; then cnt_clr=1 with StallF=1 -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// Pipeline registers for a 5-stage MIPS-style core: PC, IF/ID, ID/EX, EX/MEM, MEM/WB,
// plus saturating stall/flush event counters for the hazard unit.
module pipe_stage_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        FlushD,
  input  logic        cnt_clr,
  input  logic [31:0] PCNextF,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  input  logic [7:0]  CtrlD,
  input  logic [95:0] DataD,
  input  logic [14:0] RegsD,
  output logic [7:0]  CtrlE,
  output logic [95:0] DataE,
  output logic [14:0] RegsE,
  input  logic [2:0]  CtrlE2M,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  output logic [2:0]  CtrlM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM,
  input  logic [31:0] ReadDataM,
  output logic [1:0]  CtrlW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d, pcp4_q, pcp4_d;
  logic [7:0]  ctrle_q, ctrle_d;
  logic [95:0] datae_q, datae_d;
  logic [14:0] regse_q, regse_d;
  logic [2:0]  ctrlm_q;
  logic [31:0] aluoutm_q, wdatam_q;
  logic [4:0]  wregm_q;
  logic [1:0]  ctrlw_q;
  logic [31:0] rdataw_q, aluoutw_q;
  logic [4:0]  wregw_q;
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  logic        flush_ev;

  always_comb pc_d = StallF ? pc_q : PCNextF;

  // Stall outranks flush: a stalled decode keeps its instruction even on a taken branch.
  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    if (!StallD) begin
      if (FlushD) begin
        instr_d = '0;
        pcp4_d  = '0;
      end else begin
        instr_d = InstrF;
        pcp4_d  = PCPlus4F;
      end
    end
  end

  always_comb begin
    ctrle_d = FlushE ? '0 : CtrlD;
    datae_d = FlushE ? '0 : DataD;
    regse_d = FlushE ? '0 : RegsD;
  end

  // A suppressed FlushD (decode stalled) is not a flush event.
  assign flush_ev = FlushE | (FlushD & ~StallD);

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (StallF   && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      if (flush_ev && flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      instr_q   <= '0;
      pcp4_q    <= '0;
      ctrle_q   <= '0;
      datae_q   <= '0;
      regse_q   <= '0;
      ctrlm_q   <= '0;
      aluoutm_q <= '0;
      wdatam_q  <= '0;
      wregm_q   <= '0;
      ctrlw_q   <= '0;
      rdataw_q  <= '0;
      aluoutw_q <= '0;
      wregw_q   <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcp4_q    <= pcp4_d;
      ctrle_q   <= ctrle_d;
      datae_q   <= datae_d;
      regse_q   <= regse_d;
      ctrlm_q   <= CtrlE2M;
      aluoutm_q <= ALUOutE;
      wdatam_q  <= WriteDataE;
      wregm_q   <= WriteRegE;
      ctrlw_q   <= ctrlm_q[2:1];
      rdataw_q  <= ReadDataM;
      aluoutw_q <= aluoutm_q;
      wregw_q   <= wregm_q;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PCPlus4D   = pcp4_q;
  assign CtrlE      = ctrle_q;
  assign DataE      = datae_q;
  assign RegsE      = regse_q;
  assign CtrlM      = ctrlm_q;
  assign ALUOutM    = aluoutm_q;
  assign WriteDataM = wdatam_q;
  assign WriteRegM  = wregm_q;
  assign CtrlW      = ctrlw_q;
  assign ReadDataW  = rdataw_q;
  assign ALUOutW    = aluoutw_q;
  assign WriteRegW  = wregw_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized bench for pipe_stage_regs: a behavioural model checked every cycle,
// plus directed literal checks for the stall/flush/reset/saturation corner cases.
module tb_pipe_stage_regs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushE, FlushD, cnt_clr;
  logic [31:0] PCNextF, PCF, InstrF, PCPlus4F, InstrD, PCPlus4D;
  logic [7:0]  CtrlD, CtrlE;
  logic [95:0] DataD, DataE;
  logic [14:0] RegsD, RegsE;
  logic [2:0]  CtrlE2M, CtrlM;
  logic [31:0] ALUOutE, WriteDataE, ALUOutM, WriteDataM;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic [31:0] ReadDataM, ReadDataW, ALUOutW;
  logic [1:0]  CtrlW;
  logic [15:0] stall_cnt, flush_cnt;

  int ncmp = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // The EX stage forwards the top three control bits of ID/EX into EX/MEM.
  assign CtrlE2M = CtrlE[7:5];

  pipe_stage_regs dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .FlushD(FlushD), .cnt_clr(cnt_clr), .PCNextF(PCNextF), .PCF(PCF), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .CtrlD(CtrlD),
    .DataD(DataD), .RegsD(RegsD), .CtrlE(CtrlE), .DataE(DataE), .RegsE(RegsE),
    .CtrlE2M(CtrlE2M), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .CtrlM(CtrlM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .ReadDataM(ReadDataM), .CtrlW(CtrlW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .WriteRegW(WriteRegW), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: what each output must hold, derived from the stage rules.
  logic [31:0] m_pc, m_instr, m_pcp4, m_aluM, m_wdM, m_rdW, m_aluW;
  logic [7:0]  m_ctrlE;
  logic [95:0] m_dataE;
  logic [14:0] m_regsE;
  logic [2:0]  m_ctrlM;
  logic [1:0]  m_ctrlW;
  logic [4:0]  m_wrM, m_wrW;
  int          m_stall, m_flush;

  function automatic int sat_inc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 0; m_instr <= 0; m_pcp4 <= 0; m_ctrlE <= 0; m_dataE <= 0; m_regsE <= 0;
      m_ctrlM <= 0; m_aluM <= 0; m_wdM <= 0; m_wrM <= 0; m_ctrlW <= 0; m_rdW <= 0;
      m_aluW <= 0; m_wrW <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (!StallF) m_pc <= PCNextF;
      if (!StallD) begin
        m_instr <= FlushD ? 32'h0 : InstrF;
        m_pcp4  <= FlushD ? 32'h0 : PCPlus4F;
      end
      m_ctrlE <= FlushE ? 8'h0  : CtrlD;
      m_dataE <= FlushE ? 96'h0 : DataD;
      m_regsE <= FlushE ? 15'h0 : RegsD;
      m_ctrlM <= m_ctrlE[7:5];
      m_aluM  <= ALUOutE;
      m_wdM   <= WriteDataE;
      m_wrM   <= WriteRegE;
      m_ctrlW <= {m_ctrlM[2], m_ctrlM[1]};
      m_rdW   <= ReadDataM;
      m_aluW  <= m_aluM;
      m_wrW   <= m_wrM;
      if (cnt_clr) begin
        m_stall <= 0;
        m_flush <= 0;
      end else begin
        if (StallF) m_stall <= sat_inc(m_stall);
        if (FlushE || (FlushD && !StallD)) m_flush <= sat_inc(m_flush);
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PCF", 96'(PCF), 96'(m_pc));
      chk("InstrD", 96'(InstrD), 96'(m_instr));
      chk("PCPlus4D", 96'(PCPlus4D), 96'(m_pcp4));
      chk("CtrlE", 96'(CtrlE), 96'(m_ctrlE));
      chk("DataE", DataE, m_dataE);
      chk("RegsE", 96'(RegsE), 96'(m_regsE));
      chk("CtrlM", 96'(CtrlM), 96'(m_ctrlM));
      chk("ALUOutM", 96'(ALUOutM), 96'(m_aluM));
      chk("WriteDataM", 96'(WriteDataM), 96'(m_wdM));
      chk("WriteRegM", 96'(WriteRegM), 96'(m_wrM));
      chk("CtrlW", 96'(CtrlW), 96'(m_ctrlW));
      chk("ReadDataW", 96'(ReadDataW), 96'(m_rdW));
      chk("ALUOutW", 96'(ALUOutW), 96'(m_aluW));
      chk("WriteRegW", 96'(WriteRegW), 96'(m_wrW));
      chk("stall_cnt", 96'(stall_cnt), 96'(m_stall[15:0]));
      chk("flush_cnt", 96'(flush_cnt), 96'(m_flush[15:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    PCNextF    = $urandom; InstrF = $urandom; PCPlus4F = $urandom;
    CtrlD      = 8'($urandom);
    DataD      = {$urandom, $urandom, $urandom};
    RegsD      = 15'($urandom);
    ALUOutE    = $urandom; WriteDataE = $urandom; WriteRegE = 5'($urandom);
    ReadDataM  = $urandom;
  endtask

  task automatic rnd_ctrl();
    StallF  = ($urandom_range(0, 3) == 0);
    StallD  = ($urandom_range(0, 3) == 0);
    FlushE  = ($urandom_range(0, 3) == 0);
    FlushD  = ($urandom_range(0, 3) == 0);
    cnt_clr = ($urandom_range(0, 31) == 0);
  endtask

  logic [31:0] pc_prev;

  initial begin
    rst_n = 1'b0;
    StallF = 0; StallD = 0; FlushE = 0; FlushD = 0; cnt_clr = 0;
    rnd_data();
    #12;
    chk("reset PCF", 96'(PCF), 96'h0);
    chk("reset CtrlE", 96'(CtrlE), 96'h0);
    chk("reset CtrlW", 96'(CtrlW), 96'h0);
    chk("reset stall_cnt", 96'(stall_cnt), 96'h0);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;

    // Straight-line flow through all stages.
    InstrF = 32'h8C09_0004; CtrlD = 8'hC4; PCNextF = 32'h0000_0040; PCPlus4F = 32'h0000_0044;
    step();
    chk("lat InstrD", 96'(InstrD), 96'h8C09_0004);
    chk("lat CtrlE", 96'(CtrlE), 96'hC4);
    chk("lat PCF", 96'(PCF), 96'h40);
    step();
    chk("lat CtrlM", 96'(CtrlM), 96'b110);
    step();
    chk("lat CtrlW", 96'(CtrlW), 96'b11);

    // Full stall with ID/EX bubble for two cycles.
    cnt_clr = 1; step(); cnt_clr = 0;
    pc_prev = PCNextF;
    StallF = 1; StallD = 1; FlushE = 1;
    PCNextF = 32'h0000_1000; InstrF = 32'h1234_5678;
    step(); step();
    chk("stall PCF", 96'(PCF), 96'(pc_prev));
    chk("stall InstrD", 96'(InstrD), 96'h8C09_0004);
    chk("flushE CtrlE", 96'(CtrlE), 96'h0);
    chk("stall stall_cnt", 96'(stall_cnt), 96'd2);
    chk("stall flush_cnt", 96'(flush_cnt), 96'd2);

    // FlushD masked by StallD, then honoured.
    StallF = 0; FlushE = 0; StallD = 1; FlushD = 1;
    step();
    chk("FlushD+StallD InstrD", 96'(InstrD), 96'h8C09_0004);
    chk("FlushD+StallD flush_cnt", 96'(flush_cnt), 96'd2);
    StallD = 0;
    step();
    chk("FlushD InstrD", 96'(InstrD), 96'h0);
    chk("FlushD PCPlus4D", 96'(PCPlus4D), 96'h0);
    chk("FlushD flush_cnt", 96'(flush_cnt), 96'd3);
    FlushD = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rnd_data(); rnd_ctrl();
      step();
    end

    // Asynchronous reset between edges, with StallF held.
    cnt_clr = 0; StallF = 1; step();
    #2 rst_n = 1'b0;
    #1;
    chk("async PCF", 96'(PCF), 96'h0);
    chk("async CtrlE", 96'(CtrlE), 96'h0);
    chk("async CtrlW", 96'(CtrlW), 96'h0);
    chk("async stall_cnt", 96'(stall_cnt), 96'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rnd_data(); rnd_ctrl();
      step();
    end

    // Drive stall_cnt to saturation.
    StallF = 0; cnt_clr = 1; step(); cnt_clr = 0;
    StallF = 1;
    for (int i = 0; i < 65534; i++) begin
      rnd_data();
      StallD = ($urandom_range(0, 1) == 0);
      FlushE = ($urandom_range(0, 1) == 0);
      FlushD = ($urandom_range(0, 1) == 0);
      step();
    end
    chk("sat preload", 96'(stall_cnt), 96'hFFFE);
    step(); step(); step();
    chk("sat hold", 96'(stall_cnt), 96'hFFFF);
    cnt_clr = 1;
    step();
    chk("clr over inc stall", 96'(stall_cnt), 96'h0);
    chk("clr over inc flush", 96'(flush_cnt), 96'h0);
    cnt_clr = 0; StallF = 0; StallD = 0; FlushE = 0; FlushD = 0;
    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
